sseg_scan_driver: RTL and testbench

- Parametrised multiplexed seven-segment scan driver: N displays × M digits, shared digit index, active-low anodes and segments.
- Adds four things to the fixed 8-digit/100 MHz driver:
  - double-buffered digit data, so updates never tear mid-frame;
  - per-digit blank and blink;
  - PWM brightness;
  - a frame-start pulse.
- Sits between the board top-level and the HEX pattern generators.

---
 rtl/sseg_pkg.sv | 17 +
 rtl/sseg_scan_timer.sv | 68 ++++++
 rtl/sseg_scan_driver.sv | 124 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
package sseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic       blank;
        logic       blink;
    } digit_t;

    function automatic int slice_of(input int dwell, input int bw);
        return dwell >> bw;
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Scan timing: PWM slices within a dwell, digit index, frame end and blink phase.
module sseg_scan_timer #(
    parameter int DIGITS       = 4,
    parameter int SLICE        = 4,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 125,
    parameter int IDX_W        = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [IDX_W-1:0]    idx,
    output logic [BRIGHT_W-1:0] phase_cnt,
    output logic                frame_end,
    output logic                blink_ph
);

    localparam int SLICE_W = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SLICE_W-1:0]  SLICE_LAST = SLICE_W'(SLICE - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [SLICE_W-1:0]  slice_cnt_r;
    logic [BRIGHT_W-1:0] phase_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [BLINK_W-1:0]  blink_cnt_r;
    logic                blink_ph_r;
    logic                slice_wrap_s;
    logic                dwell_end_s;
    logic                frame_end_s;
    logic                blink_wrap_s;

    // Wrap detection for the counter chain.
    always_comb begin
        slice_wrap_s = (slice_cnt_r == SLICE_LAST);
        dwell_end_s  = slice_wrap_s && (phase_cnt_r == {BRIGHT_W{1'b1}});
        frame_end_s  = dwell_end_s && (idx_r == IDX_LAST);
        blink_wrap_s = (blink_cnt_r == BLINK_LAST);
    end

    // Counter chain; the phase counter and digit index wrap on their natural width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slice_cnt_r <= '0;
            phase_cnt_r <= '0;
            idx_r       <= '0;
            blink_cnt_r <= '0;
            blink_ph_r  <= 1'b0;
        end else begin
            slice_cnt_r <= slice_wrap_s ? '0 : slice_cnt_r + 1'b1;
            phase_cnt_r <= slice_wrap_s ? phase_cnt_r + 1'b1 : phase_cnt_r;
            idx_r       <= dwell_end_s ? idx_r + 1'b1 : idx_r;
            if (frame_end_s) begin
                blink_cnt_r <= blink_wrap_s ? '0 : blink_cnt_r + 1'b1;
                blink_ph_r  <= blink_wrap_s ? ~blink_ph_r : blink_ph_r;
            end else begin
                blink_cnt_r <= blink_cnt_r;
                blink_ph_r  <= blink_ph_r;
            end
        end
    end

    assign idx       = idx_r;
    assign phase_cnt = phase_cnt_r;
    assign frame_end = frame_end_s;
    assign blink_ph  = blink_ph_r;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver with double-buffered digits, blank/blink,
// PWM brightness and a frame-start pulse.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DISPLAYS       = 2,
    parameter int DIGITS_PER_DISPLAY = 4,
    parameter int DWELL_CYCLES       = 100_000,
    parameter int BRIGHT_W           = 3,
    parameter int BLINK_FRAMES       = 125
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        load,
    input  logic [NUM_DISPLAYS*DIGITS_PER_DISPLAY*7-1:0] seg_in,
    input  logic [NUM_DISPLAYS*DIGITS_PER_DISPLAY-1:0]   dp_in,
    input  logic [NUM_DISPLAYS*DIGITS_PER_DISPLAY-1:0]   blank_in,
    input  logic [NUM_DISPLAYS*DIGITS_PER_DISPLAY-1:0]   blink_in,
    input  logic [BRIGHT_W-1:0]                          brightness,
    output logic [NUM_DISPLAYS*DIGITS_PER_DISPLAY-1:0]   an_out,
    output logic [NUM_DISPLAYS*8-1:0]                    seg_out,
    output logic                                         frame_start
);

    localparam int ND    = NUM_DISPLAYS * DIGITS_PER_DISPLAY;
    localparam int SLICE = slice_of(DWELL_CYCLES, BRIGHT_W);
    localparam int IDX_W = $clog2(DIGITS_PER_DISPLAY);
    localparam digit_t DIGIT_RST = '{seg: SEG_OFF, dp: 1'b0, blank: 1'b1, blink: 1'b0};

    logic [IDX_W-1:0]    idx_s;
    logic [BRIGHT_W-1:0] phase_cnt_s;
    logic                frame_end_s;
    logic                blink_ph_s;
    logic                lit_s;

    digit_t [ND-1:0]     load_s;
    digit_t [ND-1:0]     shadow_r;
    digit_t [ND-1:0]     active_r;
    logic                pending_r;

    logic [ND-1:0]             an_s;
    logic [NUM_DISPLAYS*8-1:0] seg_s;
    logic [ND-1:0]             an_r;
    logic [NUM_DISPLAYS*8-1:0] seg_r;
    logic                      frame_start_r;

    sseg_scan_timer #(
        .DIGITS       (DIGITS_PER_DISPLAY),
        .SLICE        (SLICE),
        .BRIGHT_W     (BRIGHT_W),
        .BLINK_FRAMES (BLINK_FRAMES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx_s),
        .phase_cnt (phase_cnt_s),
        .frame_end (frame_end_s),
        .blink_ph  (blink_ph_s)
    );

    // Pack the flat input buses into digit records.
    always_comb begin
        load_s = '0;
        for (int i = 0; i < ND; i++) begin
            load_s[i] = '{seg: seg_in[7*i +: 7], dp: dp_in[i], blank: blank_in[i], blink: blink_in[i]};
        end
    end

    // Shadow/active buffers; a load on the frame_end cycle lands one frame later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r  <= {ND{DIGIT_RST}};
            active_r  <= {ND{DIGIT_RST}};
            pending_r <= 1'b0;
        end else begin
            shadow_r  <= load ? load_s : shadow_r;
            active_r  <= (frame_end_s && pending_r) ? shadow_r : active_r;
            if (load) begin
                pending_r <= 1'b1;
            end else if (frame_end_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Per-display output mux for the currently scanned anode.
    always_comb begin
        an_s  = '1;
        seg_s = '1;
        lit_s = (phase_cnt_s <= brightness);
        for (int k = 0; k < NUM_DISPLAYS; k++) begin
            if (lit_s && !active_r[k*DIGITS_PER_DISPLAY + int'(idx_s)].blank &&
                !(active_r[k*DIGITS_PER_DISPLAY + int'(idx_s)].blink && blink_ph_s)) begin
                an_s[k*DIGITS_PER_DISPLAY + int'(idx_s)] = 1'b0;
                seg_s[k*8 +: 8] = {~active_r[k*DIGITS_PER_DISPLAY + int'(idx_s)].dp,
                                   active_r[k*DIGITS_PER_DISPLAY + int'(idx_s)].seg};
            end else begin
                an_s[k*DIGITS_PER_DISPLAY + int'(idx_s)] = 1'b1;
                seg_s[k*8 +: 8] = 8'hFF;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r          <= '1;
            seg_r         <= '1;
            frame_start_r <= 1'b0;
        end else begin
            an_r          <= an_s;
            seg_r         <= seg_s;
            frame_start_r <= frame_end_s;
        end
    end

    assign an_out      = an_r;
    assign seg_out     = seg_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench: a time-based reference model predicts every registered output cycle.
module tb_sseg_scan_driver;

    localparam int NDISP = 2;
    localparam int DPD   = 4;
    localparam int ND    = NDISP * DPD;
    localparam int DWELL = 16;
    localparam int BW    = 2;
    localparam int SLICE = DWELL >> BW;
    localparam int BF    = 2;
    localparam int FRAME = DWELL * DPD;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [ND*7-1:0]   seg_in;
    logic [ND-1:0]     dp_in, blank_in, blink_in;
    logic [BW-1:0]     brightness;
    logic [ND-1:0]     an_out;
    logic [NDISP*8-1:0] seg_out;
    logic              frame_start;

    sseg_scan_driver #(
        .NUM_DISPLAYS(NDISP), .DIGITS_PER_DISPLAY(DPD), .DWELL_CYCLES(DWELL),
        .BRIGHT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .seg_in(seg_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .brightness(brightness),
        .an_out(an_out), .seg_out(seg_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND-1:0]      an;
        logic [NDISP*8-1:0] seg;
        logic               fs;
        int                 t;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: images as plain arrays, time as a cycle count since reset.
    logic [ND*7-1:0] sh_seg, ac_seg;
    logic [ND-1:0]   sh_dp, ac_dp, sh_bl, ac_bl, sh_bk, ac_bk;
    bit              pend;
    int              t;

    task automatic model_reset();
        sh_seg = '1; ac_seg = '1;
        sh_dp  = '0; ac_dp  = '0;
        sh_bl  = '1; ac_bl  = '1;
        sh_bk  = '0; ac_bk  = '0;
        pend   = 1'b0;
        t      = 0;
    endtask

    // One clock: predict the output that the state at cycle t produces, then advance.
    task automatic step(input bit ld);
        exp_t e;
        int ph, ix, fr, i;
        bit bph, lit;
        load = ld;
        ph  = (t % DWELL) / SLICE;
        ix  = (t / DWELL) % DPD;
        fr  = t / FRAME;
        bph = ((fr / BF) % 2) == 1;
        lit = ph <= int'(brightness);
        e.an = '1; e.seg = '1; e.t = t;
        for (int k = 0; k < NDISP; k++) begin
            i = k * DPD + ix;
            if (lit && !ac_bl[i] && !(ac_bk[i] && bph)) begin
                e.an[i] = 1'b0;
                e.seg[k*8 +: 8] = {~ac_dp[i], ac_seg[i*7 +: 7]};
            end
        end
        e.fs = (t % FRAME) == FRAME - 1;
        q.push_back(e);
        if (e.fs && pend) begin
            ac_seg = sh_seg; ac_dp = sh_dp; ac_bl = sh_bl; ac_bk = sh_bk;
            pend = 1'b0;
        end
        if (ld) begin
            sh_seg = seg_in; sh_dp = dp_in; sh_bl = blank_in; sh_bk = blink_in;
            pend = 1'b1;
        end
        t++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    task automatic run_to(input int pos);
        while ((t % FRAME) != pos) step(1'b0);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear immediately.
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        #1;
        total++;
        if (an_out !== 8'hFF || seg_out !== 16'hFFFF || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got an=%h seg=%h fs=%b, want an=ff seg=ffff fs=0",
                     an_out, seg_out, frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic rand_image();
        seg_in   = {$urandom, $urandom};
        dp_in    = ND'($urandom);
        blank_in = ND'($urandom) & ND'($urandom);
        blink_in = ND'($urandom);
    endtask

    // Monitor: every cycle after the active edge, compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (an_out !== e.an || seg_out !== e.seg || frame_start !== e.fs) begin
                    bad++;
                    if (bad <= 30)
                        $display("FAIL outputs t=%0d: got an=%h seg=%h fs=%b, want an=%h seg=%h fs=%b",
                                 e.t, an_out, seg_out, frame_start, e.an, e.seg, e.fs);
                end
            end
        end
    end

    initial begin
        logic [ND*7-1:0] img_a;
        reset = 1'b0; load = 1'b0;
        seg_in = '1; dp_in = '0; blank_in = '1; blink_in = '0; brightness = 2'd3;
        model_reset();
        @(negedge clk);
        do_reset();

        // Dark after reset, frame_start every 64 cycles.
        run(200);

        // Digit 0 shows 7'h40 with decimal point at full brightness.
        seg_in = '1; seg_in[6:0] = 7'h40;
        dp_in = 8'h01; blank_in = 8'hFE; blink_in = 8'h00;
        step(1'b1);
        run(140);

        // Dimmest setting: lit only during phase 0.
        brightness = 2'd0;
        run(80);
        brightness = 2'd3;

        // Load on the exact frame_end cycle, then two loads inside one frame.
        run_to(FRAME - 2);
        step(1'b0);
        img_a = {$urandom, $urandom};
        seg_in = img_a; dp_in = 8'hA5; blank_in = 8'h00; blink_in = 8'h00;
        step(1'b1);
        run(80);
        rand_image();
        step(1'b1);
        run(5);
        rand_image();
        step(1'b1);
        run(140);

        // Blink on digit 5 only.
        seg_in = {$urandom, $urandom}; dp_in = 8'h00; blank_in = 8'h00; blink_in = 8'h20;
        step(1'b1);
        run(FRAME * 5);

        // Randomized traffic with occasional loads and brightness changes.
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) brightness = BW'($urandom);
            rand_image();
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        // Reset mid-dwell while idx is 2, then confirm the display stays dark.
        run_to(2 * DWELL + 5);
        do_reset();
        run(FRAME * 2 + 10);

        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending predictions, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
